wr_ctrl_gray: RTL and testbench
===============================

# wr_ctrl_gray

Parametrised write-side controller for the dual-clock FIFO, successor to the binary-pointer write controller. Runs entirely in the write clock domain. Generates the RAM write address and strobe, publishes a Gray-coded write pointer for the read domain, and synchronises the read domain's Gray pointer through a configurable flop chain. Adds almost-full, fill level and sticky overflow reporting.

## Interface
- P_ADDR_WIDTH, 4, RAM address width N; FIFO depth = 2^N; legal range 2..12
- P_SYNC_STAGES, 2, synchroniser depth for i_rd_ptr_gray; legal range 2..4
- P_AFULL_THRESH, 14, o_afull asserts when level >= this value; legal range 1..2^N

Ports:
- i_clk  in  1  write-domain clock
- i_rst  in  1  reset; synchronous, active-high; clock i_clk
- i_inc  in  1  write request
- i_ovf_clr  in  1  clears o_overflow
- i_rd_ptr_gray  in  N+1  read pointer, Gray-coded, from the read clock domain (asynchronous)
- o_wr_en  out  1  RAM write strobe = i_inc & ~o_full (combinational)
- o_wr_addr  out  N  RAM write address = low N bits of the binary write pointer
- o_wr_ptr_gray  out  N+1  registered Gray write pointer, for the read domain
- o_full  out  1  registered full flag
- o_afull  out  1  registered almost-full flag
- o_level  out  N+1  registered occupancy as seen by the write domain, 0..2^N
- o_overflow  out  1  sticky; write attempted while full

## Operation
- Binary write pointer wbin is N+1 bits and wraps modulo 2^(N+1). wgray = wbin ^ (wbin >> 1).
- Accept: a write is accepted when i_inc & ~o_full. Then wbin_next = wbin + 1; otherwise wbin_next = wbin.
- Sync chain: P_SYNC_STAGES flops capture i_rd_ptr_gray. The last stage is rgray_s. rbin_s is derived from it by Gray-to-binary conversion: bit N = g[N]; bit i = bit i+1 ^ g[i].
- Full: full_next = (gray(wbin_next) == {~rgray_s[N:N-1], rgray_s[N-2:0]}).
- Level: level_next = (wbin_next - rbin_s) mod 2^(N+1). The result never exceeds 2^N.
- Almost-full: afull_next = (level_next >= P_AFULL_THRESH).
- Registered state: wbin, o_wr_ptr_gray, o_full, o_afull, o_level and the sync flops all register on the i_clk edge.
- Overflow: set when i_inc & o_full. Cleared by i_ovf_clr. Set wins over a simultaneous clear.
- The block has no state machine beyond the pointer. Mode is fixed by parameters.

## Timing
- Reset: wbin = 0, o_wr_addr = 0, o_wr_ptr_gray = 0, o_full = 0, o_afull = 0, o_level = 0, o_overflow = 0, all sync flops = 0. o_wr_en = i_inc after reset.
- Write path:
  - o_wr_en and o_wr_addr are valid in the same cycle as i_inc; the RAM writes on that edge.
  - o_wr_addr advances on the following edge.
- Full, zero-latency set: o_full asserts on the edge that accepts the 2^N-th unread entry. The very next i_inc is refused, with o_wr_en = 0.
- Full, delayed clear: o_full deasserts P_SYNC_STAGES+1 edges after a read-side pointer change is stable at i_rd_ptr_gray. This conservative delay is required.
- Level and almost-full: o_level and o_afull track local writes with 1-cycle latency and remote reads with P_SYNC_STAGES+1 latency. o_level never under-reports.
- Simultaneous events: a write and a read pointer update in the same cycle net out. Level is unchanged and o_full is recomputed from both.
- Wrap-around:
  - wbin rolls 2^(N+1)-1 -> 0 with no discontinuity in o_wr_ptr_gray, so exactly one bit changes per increment.
  - o_wr_addr rolls 2^N-1 -> 0.
- Mid-operation reset: takes effect on the next edge and discards all state. The read domain must be reset in the same window; this is a system requirement and not checked here.
- Gray output: o_wr_ptr_gray changes at most one bit per i_clk cycle.

## Test plan
- Reset and idle, N=4: assert i_rst 3 cycles with i_inc = 1 -> all outputs 0. First accepted write after release has o_wr_addr = 0.
- Fill to full, i_rd_ptr_gray held 0, i_inc = 1 for 20 cycles:
  - Exactly 16 o_wr_en pulses.
  - o_full = 1 after the 16th edge.
  - o_level = 16.
  - o_afull = 1 after the 14th write.
  - o_overflow = 1 on the 17th request.
- Drain release: from full, drive i_rd_ptr_gray = gray(4) = 6 -> o_full = 0 and o_level = 12 exactly P_SYNC_STAGES+1 = 3 edges later. o_afull = 0.
- Wrap: perform 40 write/read pairs with the read pointer following -> o_wr_ptr_gray changes by Hamming distance 1 every write. wbin wraps 31 -> 0. o_level stays in 0..2.
- Overflow clear: with o_full = 1, i_inc = 1 and i_ovf_clr = 1 in the same cycle -> o_overflow stays 1. i_ovf_clr alone with i_inc = 0 -> o_overflow = 0 next edge.
- Parameter sweep: repeat the fill test at N=2 with P_SYNC_STAGES = 4 and P_AFULL_THRESH = 4 -> full after 4 writes, afull together with full, release delay 5 edges.

Source files
------------

// File: rtl/wr_ctrl_gray_if.sv
// Write-side handshake bundle for the dual-clock FIFO write controller.
//   i_inc          write request
//   i_ovf_clr      clears the sticky overflow flag
//   i_rd_ptr_gray  Gray read pointer from the read clock domain (asynchronous)
//   o_wr_en        RAM write strobe (combinational)
//   o_wr_addr      RAM write address
//   o_wr_ptr_gray  registered Gray write pointer for the read domain
//   o_full         registered full flag
//   o_afull        registered almost-full flag
//   o_level        registered occupancy as seen by the write domain
//   o_overflow     sticky write-while-full flag
// master: the requester driving writes; slave: the controller.
interface wr_ctrl_gray_if #(
  parameter int unsigned P_ADDR_WIDTH = 4
);
  logic                    i_inc;
  logic                    i_ovf_clr;
  logic [P_ADDR_WIDTH:0]   i_rd_ptr_gray;
  logic                    o_wr_en;
  logic [P_ADDR_WIDTH-1:0] o_wr_addr;
  logic [P_ADDR_WIDTH:0]   o_wr_ptr_gray;
  logic                    o_full;
  logic                    o_afull;
  logic [P_ADDR_WIDTH:0]   o_level;
  logic                    o_overflow;

  modport master (
    output i_inc, i_ovf_clr, i_rd_ptr_gray,
    input  o_wr_en, o_wr_addr, o_wr_ptr_gray, o_full, o_afull, o_level, o_overflow
  );

  modport slave (
    input  i_inc, i_ovf_clr, i_rd_ptr_gray,
    output o_wr_en, o_wr_addr, o_wr_ptr_gray, o_full, o_afull, o_level, o_overflow
  );
endinterface

// File: rtl/wr_ctrl_gray.sv
// Write-side controller of the dual-clock FIFO, write clock domain only.
// Keeps an N+1 bit binary write pointer, publishes its Gray form, synchronises
// the read domain's Gray pointer through P_SYNC_STAGES flops and derives full,
// almost-full, fill level and a sticky overflow flag.
//   i_clk  write-domain clock
//   i_rst  synchronous, active-high reset
//   bus    wr_ctrl_gray_if.slave (see interface header for signal list)
module wr_ctrl_gray #(
  parameter int unsigned P_ADDR_WIDTH   = 4,
  parameter int unsigned P_SYNC_STAGES  = 2,
  parameter int unsigned P_AFULL_THRESH = 14
) (
  input logic           i_clk,
  input logic           i_rst,
  wr_ctrl_gray_if.slave bus
);
  localparam int unsigned AW = P_ADDR_WIDTH;
  localparam logic [AW:0] AfullThresh = P_AFULL_THRESH[AW:0];

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        afull_q, afull_d;
  logic        overflow_q, overflow_d;
  logic [AW:0] sync_q [P_SYNC_STAGES];
  logic [AW:0] rgray_s, rbin_s;
  logic        accept;

  assign rgray_s = sync_q[P_SYNC_STAGES-1];
  assign accept  = bus.i_inc & ~full_q;

  always_comb begin
    rbin_s = '0;
    // Binary bit i is the XOR of all Gray bits at and above i.
    for (int i = 0; i <= int'(AW); i++) begin
      rbin_s[i] = ^(rgray_s >> i);
    end
  end

  always_comb begin
    wbin_d     = wbin_q + {{AW{1'b0}}, accept};
    wgray_d    = wbin_d ^ (wbin_d >> 1);
    // Full when the pointers differ only in the wrap bit, which in Gray form
    // inverts the top two bits.
    full_d     = (wgray_d == {~rgray_s[AW:AW-1], rgray_s[AW-2:0]});
    // Stale read pointer can only make this over-report, never under-report.
    level_d    = wbin_d - rbin_s;
    afull_d    = (level_d >= AfullThresh);
    overflow_d = (bus.i_inc & full_q) | (overflow_q & ~bus.i_ovf_clr);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wbin_q     <= '0;
      wgray_q    <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
      overflow_q <= 1'b0;
      for (int i = 0; i < int'(P_SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      wbin_q     <= wbin_d;
      wgray_q    <= wgray_d;
      level_q    <= level_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
      overflow_q <= overflow_d;
      sync_q[0]  <= bus.i_rd_ptr_gray;
      for (int i = 1; i < int'(P_SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign bus.o_wr_en       = accept;
  assign bus.o_wr_addr     = wbin_q[AW-1:0];
  assign bus.o_wr_ptr_gray = wgray_q;
  assign bus.o_full        = full_q;
  assign bus.o_afull       = afull_q;
  assign bus.o_level       = level_q;
  assign bus.o_overflow    = overflow_q;
endmodule

// File: tb/tb_wr_ctrl_gray.sv
// Directed bench for wr_ctrl_gray: a default N=4 instance and an N=2,
// 4-stage-sync, threshold-4 instance, both driven from one sequence.
module tb_wr_ctrl_gray;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 i_clk = ~i_clk;

  wr_ctrl_gray_if #(.P_ADDR_WIDTH(4)) bus_a ();
  wr_ctrl_gray_if #(.P_ADDR_WIDTH(2)) bus_b ();

  wr_ctrl_gray #(
    .P_ADDR_WIDTH(4), .P_SYNC_STAGES(2), .P_AFULL_THRESH(14)
  ) u_dut_a (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus_a)
  );

  wr_ctrl_gray #(
    .P_ADDR_WIDTH(2), .P_SYNC_STAGES(4), .P_AFULL_THRESH(4)
  ) u_dut_b (
    .i_clk(i_clk), .i_rst(i_rst), .bus(bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [4:0] gray5(input int unsigned v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  int          pulses;
  int unsigned cnt;
  int unsigned n;
  logic [4:0]  prev_gray;

  initial begin
    bus_a.i_inc = 1'b1;
    bus_a.i_ovf_clr = 1'b0;
    bus_a.i_rd_ptr_gray = '0;
    bus_b.i_inc = 1'b0;
    bus_b.i_ovf_clr = 1'b0;
    bus_b.i_rd_ptr_gray = '0;

    // Reset held 3 cycles with i_inc high.
    i_rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_addr", 32'(bus_a.o_wr_addr), 0);
    check_eq("rst_gray", 32'(bus_a.o_wr_ptr_gray), 0);
    check_eq("rst_full", 32'(bus_a.o_full), 0);
    check_eq("rst_afull", 32'(bus_a.o_afull), 0);
    check_eq("rst_level", 32'(bus_a.o_level), 0);
    check_eq("rst_ovf", 32'(bus_a.o_overflow), 0);
    check_eq("rst_wr_en", 32'(bus_a.o_wr_en), 1);

    // Fill: 20 requests against a read pointer held at 0.
    i_rst = 1'b0;
    #1;
    check_eq("first_addr", 32'(bus_a.o_wr_addr), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      n = (i + 1 > 16) ? 16 : i + 1;
      check_eq("fill_wr_en", 32'(bus_a.o_wr_en), (i < 16) ? 1 : 0);
      if (bus_a.o_wr_en) pulses++;
      tick();
      #1;
      check_eq("fill_level", 32'(bus_a.o_level), n);
      check_eq("fill_addr", 32'(bus_a.o_wr_addr), n % 16);
      check_eq("fill_full", 32'(bus_a.o_full), (i + 1 >= 16) ? 1 : 0);
      check_eq("fill_afull", 32'(bus_a.o_afull), (i + 1 >= 14) ? 1 : 0);
      check_eq("fill_ovf", 32'(bus_a.o_overflow), (i + 1 >= 17) ? 1 : 0);
    end
    check_eq("fill_pulses", 32'(pulses), 16);

    // Overflow: set beats clear, then clear alone.
    bus_a.i_ovf_clr = 1'b1;
    tick();
    check_eq("ovf_set_wins", 32'(bus_a.o_overflow), 1);
    bus_a.i_inc = 1'b0;
    tick();
    check_eq("ovf_cleared", 32'(bus_a.o_overflow), 0);
    bus_a.i_ovf_clr = 1'b0;

    // Drain release: read pointer to gray(4) = 6, full clears 3 edges later.
    bus_a.i_rd_ptr_gray = 5'd6;
    tick();
    check_eq("drain_full_e1", 32'(bus_a.o_full), 1);
    check_eq("drain_level_e1", 32'(bus_a.o_level), 16);
    tick();
    check_eq("drain_full_e2", 32'(bus_a.o_full), 1);
    tick();
    check_eq("drain_full_e3", 32'(bus_a.o_full), 0);
    check_eq("drain_level_e3", 32'(bus_a.o_level), 12);
    check_eq("drain_afull_e3", 32'(bus_a.o_afull), 0);

    // Wrap: 40 write/read pairs from a fresh reset.
    i_rst = 1'b1;
    bus_a.i_inc = 1'b0;
    bus_a.i_rd_ptr_gray = '0;
    repeat (2) tick();
    i_rst = 1'b0;
    cnt = 0;
    prev_gray = '0;
    for (int p = 0; p < 40; p++) begin
      bus_a.i_inc = 1'b1;
      #1;
      check_eq("wrap_wr_en", 32'(bus_a.o_wr_en), 1);
      check_eq("wrap_addr", 32'(bus_a.o_wr_addr), cnt % 16);
      tick();
      bus_a.i_inc = 1'b0;
      cnt++;
      check_eq("wrap_gray", 32'(bus_a.o_wr_ptr_gray), 32'(gray5(cnt)));
      check_eq("wrap_hamming", 32'($countones(bus_a.o_wr_ptr_gray ^ prev_gray)), 1);
      if (cnt == 32) check_eq("wrap_to_zero", 32'(bus_a.o_wr_ptr_gray), 0);
      check_eq("wrap_level_le2", 32'(bus_a.o_level <= 5'd2), 1);
      prev_gray = bus_a.o_wr_ptr_gray;
      bus_a.i_rd_ptr_gray = gray5(cnt);
      repeat (2) begin
        tick();
        check_eq("wrap_level_le2", 32'(bus_a.o_level <= 5'd2), 1);
      end
      tick();
      check_eq("wrap_level_zero", 32'(bus_a.o_level), 0);
    end

    // Parameter sweep: N=2, 4 sync stages, threshold 4.
    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    bus_b.i_inc = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      n = (i + 1 > 4) ? 4 : i + 1;
      check_eq("b_wr_en", 32'(bus_b.o_wr_en), (i < 4) ? 1 : 0);
      tick();
      #1;
      check_eq("b_level", 32'(bus_b.o_level), n);
      check_eq("b_full", 32'(bus_b.o_full), (i + 1 >= 4) ? 1 : 0);
      check_eq("b_afull", 32'(bus_b.o_afull), (i + 1 >= 4) ? 1 : 0);
    end
    check_eq("b_ovf", 32'(bus_b.o_overflow), 1);
    bus_b.i_inc = 1'b0;
    bus_b.i_rd_ptr_gray = 3'd1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      check_eq("b_release_full", 32'(bus_b.o_full), (e < 5) ? 1 : 0);
    end
    check_eq("b_release_level", 32'(bus_b.o_level), 3);
    check_eq("b_release_afull", 32'(bus_b.o_afull), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
